// File: rtl/layer_sequencer.sv
// layer_sequencer: walks a programmed table of layer descriptors and hands each
// layer to its engine (vector, winograd or SE). One start pulse per layer, then
// wait for that engine's done before moving on. Invalid descriptor types and
// engines that never answer end the sequence in a sticky error state; abort
// drops straight back to idle without flagging an error.
module layer_sequencer #(
  parameter int MAX_LAYERS  = 16,
  parameter int CFG_W       = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0] cfg_addr,
  input  logic [1:0]                    cfg_type,
  input  logic [CFG_W-1:0]              cfg_word,
  input  logic [$clog2(MAX_LAYERS):0]   num_layers,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          vector_done,
  input  logic                          winograd_done,
  input  logic                          se_done,
  output logic                          vector_start,
  output logic                          winograd_start,
  output logic                          se_start,
  output logic [CFG_W-1:0]              layer_cfg,
  output logic [$clog2(MAX_LAYERS)-1:0] layer_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code
);

  localparam int IW = $clog2(MAX_LAYERS);
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [IW:0]   MAX_N      = (IW+1)'(MAX_LAYERS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] TYPE_VECTOR   = 2'b00;
  localparam logic [1:0] TYPE_WINOGRAD = 2'b01;
  localparam logic [1:0] TYPE_SE       = 2'b10;
  localparam logic [1:0] TYPE_INVALID  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0]       type_mem [MAX_LAYERS];
  logic [CFG_W-1:0] cfg_mem  [MAX_LAYERS];

  logic [1:0]    type_r;
  logic [IW:0]   num_layers_r;
  logic [TW-1:0] timer;
  logic          sel_done;
  logic          run_phase;
  logic          accept_start;
  logic          last_layer;
  logic [IW:0]   num_clamped;

  // Abort only matters while a sequence is in flight; IDLE and ERROR ignore it.
  assign run_phase = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT) ||
                     (state == S_NEXT)  || (state == S_FINISH);

  assign accept_start = ((state == S_IDLE) || (state == S_ERROR)) && start;
  assign num_clamped  = (num_layers > MAX_N) ? MAX_N : num_layers;
  assign last_layer   = (({1'b0, layer_idx} + (IW+1)'(1)) == num_layers_r);

  // Pick out the done input belonging to the engine the current layer was sent to.
  always_comb begin
    sel_done = 1'b0;
    case (type_r)
      TYPE_VECTOR:   sel_done = vector_done;
      TYPE_WINOGRAD: sel_done = winograd_done;
      TYPE_SE:       sel_done = se_done;
      default:       sel_done = 1'b0;
    endcase
  end

  // Descriptor table: writable only while no sequence is walking it.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      type_mem[cfg_addr] <= cfg_type;
      cfg_mem[cfg_addr]  <= cfg_word;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the start/done pulses, which abort masks in its cycle.
  always_comb begin
    next_state     = state;
    vector_start   = 1'b0;
    winograd_start = 1'b0;
    se_start       = 1'b0;
    done           = 1'b0;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          next_state = (num_layers != '0) ? S_FETCH : S_FINISH;
        end
      end
      S_FETCH: next_state = S_ISSUE;
      S_ISSUE: begin
        if (type_r == TYPE_INVALID) begin
          next_state = S_ERROR;
        end else begin
          next_state     = S_WAIT;
          vector_start   = (type_r == TYPE_VECTOR);
          winograd_start = (type_r == TYPE_WINOGRAD);
          se_start       = (type_r == TYPE_SE);
        end
      end
      S_WAIT: begin
        if (sel_done) begin
          next_state = S_NEXT;
        end else if (timer == TIMER_LAST) begin
          next_state = S_ERROR;
        end
      end
      S_NEXT: next_state = last_layer ? S_FINISH : S_FETCH;
      S_FINISH: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort && run_phase) begin
      next_state     = S_IDLE;
      vector_start   = 1'b0;
      winograd_start = 1'b0;
      se_start       = 1'b0;
      done           = 1'b0;
    end
  end

  // Sequencing datapath: layer index, latched layer count, fetched descriptor, WAIT timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      layer_idx    <= '0;
      num_layers_r <= '0;
      type_r       <= '0;
      layer_cfg    <= '0;
      timer        <= '0;
    end else begin
      busy <= (next_state == S_FETCH) || (next_state == S_ISSUE) ||
              (next_state == S_WAIT)  || (next_state == S_NEXT);
      if (accept_start) begin
        layer_idx    <= '0;
        num_layers_r <= num_clamped;
      end else if ((state == S_NEXT) && (next_state == S_FETCH)) begin
        layer_idx <= layer_idx + IW'(1);
      end
      if ((state == S_FETCH) && !abort) begin
        type_r    <= type_mem[layer_idx];
        layer_cfg <= cfg_mem[layer_idx];
      end
      if (state == S_ISSUE) begin
        timer <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + TW'(1);
      end
    end
  end

  // Sticky error flag and code; only a newly accepted start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else if (accept_start) begin
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else if ((state == S_ISSUE) && (next_state == S_ERROR)) begin
      error    <= 1'b1;
      err_code <= ERR_INVALID;
    end else if ((state == S_WAIT) && (next_state == S_ERROR)) begin
      error    <= 1'b1;
      err_code <= ERR_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized checks of layer_sequencer against a timeline
// model that predicts, for each cycle, which engine start fires, when done
// pulses, when busy is high and what the error flags read.
`timescale 1ns/1ps
module tb_layer_sequencer;

  localparam int MAXL    = 16;
  localparam int TO      = 16;
  localparam int K_DONE  = 0;
  localparam int K_E_INV = 1;
  localparam int K_E_TO  = 2;
  localparam int K_ABORT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [1:0]  cfg_type;
  logic [31:0] cfg_word;
  logic [4:0]  num_layers;
  logic        start;
  logic        abort;
  logic        vector_done;
  logic        winograd_done;
  logic        se_done;
  logic        vector_start;
  logic        winograd_start;
  logic        se_start;
  logic [31:0] layer_cfg;
  logic [3:0]  layer_idx;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int vec_count = 0;
  int err_count = 0;

  logic [1:0]  mdl_type [MAXL];
  logic [31:0] mdl_cfg  [MAXL];
  int          lat      [MAXL];
  logic        prev_err;
  logic [1:0]  prev_code;

  layer_sequencer #(
    .MAX_LAYERS(MAXL),
    .CFG_W(32),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_type(cfg_type),
    .cfg_word(cfg_word),
    .num_layers(num_layers),
    .start(start),
    .abort(abort),
    .vector_done(vector_done),
    .winograd_done(winograd_done),
    .se_done(se_done),
    .vector_start(vector_start),
    .winograd_start(winograd_start),
    .se_start(se_start),
    .layer_cfg(layer_cfg),
    .layer_idx(layer_idx),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Engine selected by a descriptor type, as {se, winograd, vector}.
  function automatic logic [2:0] engine_bits(input logic [1:0] ty);
    case (ty)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic write_entry(input int i, input logic [1:0] ty, input logic [31:0] w);
    cfg_we   = 1'b1;
    cfg_addr = i[3:0];
    cfg_type = ty;
    cfg_word = w;
    @(posedge clk);
    #1;
    cfg_we      = 1'b0;
    mdl_type[i] = ty;
    mdl_cfg[i]  = w;
  endtask

  // Run one sequence, predicting every cycle from the layer list and engine latencies.
  task automatic run_seq(input string tag, input int n_req, input int abort_layer);
    int n, p, t, end_cyc, busy_end, kind, err_idx, abort_cyc, total, act, win;
    int pulse_cyc [MAXL];
    int done_cyc  [MAXL];
    logic [2:0] exp_pulse, got_pulse, dn, noise;
    logic       exp_done, exp_busy, exp_err;
    logic [1:0] exp_code;

    n         = (n_req > MAXL) ? MAXL : n_req;
    kind      = K_DONE;
    err_idx   = 0;
    abort_cyc = -1;
    end_cyc   = 1;
    p         = 2;
    for (int i = 0; i < MAXL; i++) begin
      pulse_cyc[i] = -1;
      done_cyc[i]  = -1;
    end
    for (int i = 0; i < n; i++) begin
      if (mdl_type[i] == 2'b11) begin
        kind = K_E_INV; end_cyc = p + 1; err_idx = i;
        break;
      end
      pulse_cyc[i] = p;
      if (i == abort_layer) begin
        win = (lat[i] < 1 || lat[i] > TO) ? TO : lat[i];
        if (win < 2) win = 2;
        abort_cyc = p + 1 + int'($urandom_range(0, win - 2));
        kind = K_ABORT; end_cyc = abort_cyc;
        break;
      end
      if (lat[i] < 1 || lat[i] > TO) begin
        kind = K_E_TO; end_cyc = p + TO + 1; err_idx = i;
        break;
      end
      t = p + lat[i];
      done_cyc[i] = t;
      if (i == n - 1) end_cyc = t + 2;
      else p = t + 3;
    end
    busy_end = (kind == K_ABORT) ? end_cyc + 1 : end_cyc;
    total    = end_cyc + 3;

    for (int c = 0; c < total; c++) begin
      act = -1;
      for (int i = 0; i < MAXL; i++) begin
        if (pulse_cyc[i] >= 0 && pulse_cyc[i] < c) act = i;
      end
      noise = 3'($urandom_range(0, 7));
      if (act >= 0) noise = noise & ~engine_bits(mdl_type[act]);
      dn = noise;
      for (int i = 0; i < MAXL; i++) begin
        if (done_cyc[i] == c) dn = dn | engine_bits(mdl_type[i]);
      end
      vector_done   = dn[0];
      winograd_done = dn[1];
      se_done       = dn[2];
      exp_busy   = (c >= 1) && (c < busy_end);
      start      = (c == 0) || (exp_busy && ($urandom_range(0, 3) == 0));
      num_layers = (c == 0) ? 5'(n_req) : 5'($urandom_range(0, 31));
      abort      = (c == abort_cyc) || (((c == 0) || (c > end_cyc)) && ($urandom_range(0, 1) == 1));
      cfg_we     = exp_busy && ($urandom_range(0, 1) == 1);
      cfg_addr   = 4'($urandom_range(0, 15));
      cfg_type   = 2'($urandom_range(0, 3));
      cfg_word   = $urandom();

      exp_pulse = 3'b000;
      for (int i = 0; i < MAXL; i++) begin
        if (pulse_cyc[i] == c) exp_pulse = engine_bits(mdl_type[i]);
      end
      exp_done = (kind == K_DONE) && (c == end_cyc);
      if (c == 0) begin
        exp_err = prev_err; exp_code = prev_code;
      end else if ((kind == K_E_INV || kind == K_E_TO) && c >= end_cyc) begin
        exp_err = 1'b1; exp_code = (kind == K_E_INV) ? 2'b01 : 2'b10;
      end else begin
        exp_err = 1'b0; exp_code = 2'b00;
      end

      @(negedge clk);
      got_pulse = {se_start, winograd_start, vector_start};
      vec_count++;
      if (got_pulse !== exp_pulse) begin
        err_count++;
        $display("[TB] FAIL %s start_pulses cyc %0d: got %b want %b", tag, c, got_pulse, exp_pulse);
      end
      vec_count++;
      if (done !== exp_done) begin
        err_count++;
        $display("[TB] FAIL %s done cyc %0d: got %b want %b", tag, c, done, exp_done);
      end
      vec_count++;
      if (busy !== exp_busy) begin
        err_count++;
        $display("[TB] FAIL %s busy cyc %0d: got %b want %b", tag, c, busy, exp_busy);
      end
      vec_count++;
      if (error !== exp_err || err_code !== exp_code) begin
        err_count++;
        $display("[TB] FAIL %s error cyc %0d: got %b/%b want %b/%b", tag, c, error, err_code, exp_err, exp_code);
      end
      for (int i = 0; i < MAXL; i++) begin
        if (pulse_cyc[i] == c) begin
          vec_count++;
          if (layer_cfg !== mdl_cfg[i] || layer_idx !== 4'(i)) begin
            err_count++;
            $display("[TB] FAIL %s layer_cfg cyc %0d: got idx %0d cfg %h want idx %0d cfg %h",
                     tag, c, layer_idx, layer_cfg, i, mdl_cfg[i]);
          end
        end
      end
      if ((kind == K_E_INV || kind == K_E_TO) && c >= end_cyc) begin
        vec_count++;
        if (layer_idx !== 4'(err_idx)) begin
          err_count++;
          $display("[TB] FAIL %s fault_idx cyc %0d: got %0d want %0d", tag, c, layer_idx, err_idx);
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    vector_done = 1'b0; winograd_done = 1'b0; se_done = 1'b0;
    prev_err  = (kind == K_E_INV || kind == K_E_TO);
    prev_code = (kind == K_E_INV) ? 2'b01 : ((kind == K_E_TO) ? 2'b10 : 2'b00);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_count++;
    if ({vector_start, winograd_start, se_start, busy, done, error} !== 6'b0 ||
        err_code !== 2'b00 || layer_idx !== 4'd0 || layer_cfg !== 32'd0) begin
      err_count++;
      $display("[TB] FAIL reset_outputs: got st %b%b%b busy %b done %b err %b/%b idx %0d cfg %h want all zero",
               vector_start, winograd_start, se_start, busy, done, error, err_code, layer_idx, layer_cfg);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    write_entry(0, 2'b00, 32'h0000_00A0);
    write_entry(1, 2'b01, 32'h0000_00A1);
    write_entry(2, 2'b10, 32'h0000_00A2);
    for (int i = 0; i < 3; i++) lat[i] = int'($urandom_range(1, 8));
    run_seq("basic", 3, -1);
  endtask

  task automatic test_zero_layers();
    run_seq("zero_layers", 0, -1);
  endtask

  task automatic test_invalid_type();
    write_entry(1, 2'b11, 32'h0000_0BAD);
    run_seq("invalid_type", 3, -1);
    write_entry(1, 2'b01, 32'h0000_00B1);
    run_seq("clear_error", 3, -1);
  endtask

  task automatic test_timeout();
    lat[0] = 0;
    lat[1] = 3;
    run_seq("timeout", 2, -1);
  endtask

  task automatic test_done_at_timeout();
    lat[0] = TO;
    lat[1] = 1;
    run_seq("done_at_timeout", 2, -1);
  endtask

  task automatic test_abort();
    lat[0] = 2;
    lat[1] = int'($urandom_range(4, TO));
    lat[2] = 2;
    run_seq("abort", 3, 1);
  endtask

  task automatic test_random();
    int n_req, ab;
    for (int i = 0; i < MAXL; i++) begin
      write_entry(i, ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), $urandom());
    end
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 2; k++) begin
        write_entry(int'($urandom_range(0, MAXL - 1)),
                    ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), $urandom());
      end
      for (int i = 0; i < MAXL; i++) begin
        lat[i] = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, TO));
      end
      n_req = int'($urandom_range(0, 31));
      ab = -1;
      if ($urandom_range(0, 3) == 0 && n_req > 0) begin
        ab = int'($urandom_range(0, ((n_req > MAXL) ? MAXL : n_req) - 1));
        lat[ab] = int'($urandom_range(2, TO));
      end
      run_seq("random", n_req, ab);
    end
  endtask

  task automatic test_reset_midrun();
    write_entry(0, 2'b00, 32'h5EED_0000);
    num_layers = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vec_count++;
    if (busy !== 1'b1) begin
      err_count++;
      $display("[TB] FAIL midrun_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vec_count++;
    if ({vector_start, winograd_start, se_start, busy, done, error} !== 6'b0 || layer_idx !== 4'd0) begin
      err_count++;
      $display("[TB] FAIL midrun_reset: got st %b%b%b busy %b done %b err %b idx %0d want all zero",
               vector_start, winograd_start, se_start, busy, done, error, layer_idx);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_err = 1'b0;
    prev_code = 2'b00;
  endtask

  // Test sequence: reset, directed scenarios, then randomized sequences.
  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_type = '0; cfg_word = '0;
    num_layers = '0; start = 1'b0; abort = 1'b0;
    vector_done = 1'b0; winograd_done = 1'b0; se_done = 1'b0;
    prev_err = 1'b0; prev_code = 2'b00;
    for (int i = 0; i < MAXL; i++) lat[i] = 1;
    test_reset();
    test_basic();
    test_zero_layers();
    test_invalid_type();
    test_timeout();
    test_done_at_timeout();
    test_abort();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
